alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Queues ALU operations in a small FIFO, drives one operation at a time onto an
// external combinational ALU, and returns each result with a wrapping sequence tag.
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_aluCnt,
    input  logic [31:0]              req_input1,
    input  logic [31:0]              req_input2,
    input  logic [4:0]               req_shamt,
    output logic [3:0]               alu_aluCnt,
    output logic [31:0]              alu_input1,
    output logic [31:0]              alu_input2,
    output logic [4:0]               alu_shamt,
    input  logic [31:0]              alu_result,
    input  logic                     alu_zero,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_result,
    output logic                     rsp_zero,
    output logic [TAGW-1:0]          rsp_tag,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    typedef struct packed {
        logic [3:0]      alucnt;
        logic [31:0]     in1;
        logic [31:0]     in2;
        logic [4:0]      shamt;
        logic [TAGW-1:0] tag;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          op;
    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_q;
    logic [TAGW-1:0] tag_cnt;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;

    // Handshake decisions use registered state only, so req_ready never sees a same-cycle pop.
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == (AW+1)'(DEPTH));
        push  = req_valid && !full && !rst;
        pop   = !empty && ((state == IDLE) || (state == HOLD && rsp_ready));
    end

    // NOTE: the FIFO storage has no reset; count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{alucnt: req_aluCnt, in1: req_input1, in2: req_input2,
                             shamt: req_shamt, tag: tag_cnt};
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            tag_cnt    <= '0;
            op         <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_tag    <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                tag_cnt <= tag_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                op     <= mem[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            unique case (state)
                IDLE: begin
                    if (pop) state <= DRIVE;
                end
                DRIVE: begin
                    rsp_valid  <= 1'b1;
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_tag    <= op.tag;
                    state      <= HOLD;
                end
                HOLD: begin
                    // Chain straight into the next operation when the queue has one waiting.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= pop ? DRIVE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = !full;
    assign alu_aluCnt = op.alucnt;
    assign alu_input1 = op.in1;
    assign alu_input2 = op.in2;
    assign alu_shamt  = op.shamt;
    assign busy       = (state != IDLE) || !empty;
    assign count      = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a stub adder ALU; expected responses
// are queued when requests are accepted and compared as responses are consumed.
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;
    localparam int TAGW  = 2;

    typedef struct {
        logic [31:0]     result;
        logic            zero;
        logic [TAGW-1:0] tag;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   req_valid;
    logic                   req_ready;
    logic [3:0]             req_aluCnt;
    logic [31:0]            req_input1;
    logic [31:0]            req_input2;
    logic [4:0]             req_shamt;
    logic [3:0]             alu_aluCnt;
    logic [31:0]            alu_input1;
    logic [31:0]            alu_input2;
    logic [4:0]             alu_shamt;
    logic [31:0]            alu_result;
    logic                   alu_zero;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [31:0]            rsp_result;
    logic                   rsp_zero;
    logic [TAGW-1:0]        rsp_tag;
    logic                   busy;
    logic [$clog2(DEPTH):0] count;

    exp_t            exp_q[$];
    logic [TAGW-1:0] tag_model;
    int              n_cmp = 0;
    int              n_err = 0;

    alu_op_sequencer #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_aluCnt(req_aluCnt), .req_input1(req_input1),
        .req_input2(req_input2), .req_shamt(req_shamt),
        .alu_aluCnt(alu_aluCnt), .alu_input1(alu_input1),
        .alu_input2(alu_input2), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
        .busy(busy), .count(count)
    );

    assign alu_result = alu_input1 + alu_input2;
    assign alu_zero   = (alu_result == 32'd0);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Responses are consumed at the next rising edge; inputs only change #1 after a rising edge.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("stray_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_result", rsp_result, e.result);
                check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        exp_q.delete();
        tag_model = '0;
        tick();
        rst = 1'b0;
    endtask

    // Offers one request and returns #1 after the edge that accepted it.
    task automatic push_req(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        req_valid  = 1'b1;
        req_aluCnt = 4'd0;
        req_input1 = a;
        req_input2 = b;
        req_shamt  = 5'd0;
        @(posedge clk);
        e.result  = a + b;
        e.zero    = ((a + b) == 32'd0);
        e.tag     = tag_model;
        exp_q.push_back(e);
        tag_model = tag_model + 1'b1;
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && (exp_q.size() != 0 || busy); i++) tick();
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic wait_rsp_valid();
        for (int i = 0; i < 20 && !rsp_valid; i++) tick();
        check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        // Reset with a request offered throughout: nothing may be accepted.
        rst        = 1'b1;
        rsp_ready  = 1'b1;
        req_valid  = 1'b1;
        req_aluCnt = 4'd5;
        req_input1 = 32'd7;
        req_input2 = 32'd8;
        req_shamt  = 5'd3;
        tag_model  = '0;
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_alu_input1", alu_input1, 32'd0);
        check("rst_alu_shamt", 32'(alu_shamt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        tick();
        check("no_accept_in_rst", 32'(count), 32'd0);

        // Single op: rsp_valid rises on the third edge counting the accepting edge.
        push_req(32'd6, 32'd3);
        check("lat_e1_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("lat_e2_valid", 32'(rsp_valid), 32'd0);
        check("drive_input1", alu_input1, 32'd6);
        check("drive_input2", alu_input2, 32'd3);
        tick();
        check("lat_e3_valid", 32'(rsp_valid), 32'd1);
        wait_drain();
        check("hold_input1", alu_input1, 32'd6);

        // Zero flag.
        push_req(32'd0, 32'd0);
        wait_drain();

        // Fill under backpressure, then release; tags restart from reset and wrap.
        do_reset();
        rsp_ready = 1'b0;
        push_req(32'd10, 32'd4);
        push_req(32'd4, 32'd12);
        push_req(32'd1, 32'd1);
        push_req(32'd2, 32'd2);
        push_req(32'd3, 32'd3);
        check("full_req_ready", 32'(req_ready), 32'd0);
        check("full_count", 32'(count), 32'(DEPTH));
        check("full_hold_valid", 32'(rsp_valid), 32'd1);
        req_valid  = 1'b1;
        req_input1 = 32'd99;
        req_input2 = 32'd1;
        tick();
        tick();
        check("no_push_when_full", 32'(count), 32'(DEPTH));
        check("hold_stable_result", rsp_result, 32'd14);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();

        // Push on the same edge as a HOLD->DRIVE pop keeps occupancy constant.
        rsp_ready = 1'b0;
        push_req(32'd20, 32'd1);
        push_req(32'd21, 32'd1);
        push_req(32'd22, 32'd1);
        wait_rsp_valid();
        check("pre_simul_count", 32'(count), 32'd2);
        rsp_ready = 1'b1;
        push_req(32'd23, 32'd1);
        check("simul_count", 32'(count), 32'd2);
        wait_drain();

        // Reset while holding a response with two entries queued.
        rsp_ready = 1'b0;
        push_req(32'd30, 32'd1);
        push_req(32'd31, 32'd1);
        push_req(32'd32, 32'd1);
        wait_rsp_valid();
        check("pre_rst_count", 32'(count), 32'd2);
        do_reset();
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rsp_ready = 1'b1;
        repeat (10) tick();
        push_req(32'd40, 32'd2);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
